// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle RISC-V main controller sequencing fetch/decode/execute/memory/writeback.
module main_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               reg_write,
  output logic [1:0]         imm_src,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [STATE_W-1:0] {
    FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5,
    EXECUTER = 6, EXECUTEI = 7, ALUWB = 8, BEQ = 9, JAL = 10
  } state_t;
  state_t cur, nxt;
  logic pc_update, branch, mem_wr, ir_wr, reg_wr, illegal;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cur <= FETCH;
    else cur <= nxt;
  always_comb begin
    nxt = FETCH;
    pc_update = 1'b0;
    branch = 1'b0;
    adr_src = 1'b0;
    mem_wr = 1'b0;
    ir_wr = 1'b0;
    reg_wr = 1'b0;
    illegal = 1'b0;
    result_src = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    case (cur)
      FETCH: begin
        nxt = DECODE;
        ir_wr = 1'b1;
        pc_update = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R: nxt = EXECUTER;
          OP_I: nxt = EXECUTEI;
          OP_BEQ: nxt = BEQ;
          OP_JAL: nxt = JAL;
          default: illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        nxt = op == OP_LW ? MEMREAD : MEMWRITE;
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        nxt = MEMWB;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_wr = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_wr = 1'b1;
      end
      EXECUTER: begin
        nxt = ALUWB;
        alu_src_a = 2'b10;
        alu_op = 2'b10;
      end
      EXECUTEI: begin
        nxt = ALUWB;
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op = 2'b10;
      end
      ALUWB: reg_wr = 1'b1;
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op = 2'b01;
        branch = 1'b1;
      end
      JAL: begin
        nxt = ALUWB;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end
  // write strobes are gated by rst_n so nothing commits while reset is held
  assign pc_write = rst_n & (pc_update | (branch & zero));
  assign mem_write = rst_n & mem_wr;
  assign ir_write = rst_n & ir_wr;
  assign reg_write = rst_n & reg_wr;
  assign illegal_op = rst_n & illegal;
  assign imm_src = op == OP_SW ? 2'b01 : op == OP_BEQ ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
  assign state = cur;
endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: table-driven directed check of the main controller plus reset corner cases.
module tb_main_control_fsm;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [6:0] op = 7'b0000011;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [3:0] state;
  int errors = 0, checks = 0;
  main_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .imm_src(imm_src),
    .illegal_op(illegal_op), .state(state)
  );
  always #5 clk = ~clk;
  // {pc_write,adr_src,mem_write,ir_write,reg_write,illegal_op,result_src,alu_src_a,alu_src_b,alu_op,imm_src}
  wire [15:0] outs = {pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op,
                      result_src, alu_src_a, alu_src_b, alu_op, imm_src};
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b0000000;
  localparam logic [15:0] E_F = 16'b100100_10_00_10_00_00;
  localparam logic [15:0] E_D = 16'b000000_00_01_01_00_00;
  localparam logic [15:0] E_MA = 16'b000000_00_10_01_00_00;
  localparam logic [15:0] E_MR = 16'b010000_00_00_00_00_00;
  localparam logic [15:0] E_MWB = 16'b000010_01_00_00_00_00;
  localparam logic [15:0] E_MW = 16'b011000_00_00_00_00_00;
  localparam logic [15:0] E_ER = 16'b000000_00_10_00_10_00;
  localparam logic [15:0] E_EI = 16'b000000_00_10_01_10_00;
  localparam logic [15:0] E_AW = 16'b000010_00_00_00_00_00;
  localparam logic [15:0] E_B = 16'b000000_00_10_00_01_00;
  localparam logic [15:0] E_J = 16'b100000_00_01_10_00_00;
  localparam logic [15:0] E_RST = 16'b000000_10_00_10_00_00;
  localparam logic [15:0] PCW = 16'h8000, ILL = 16'h0400;
  typedef struct packed {
    logic [6:0]  op;
    logic        zero;
    logic [3:0]  st;
    logic [15:0] o;
  } vec_t;
  vec_t v[$];
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  initial begin
    v.push_back('{LW, 1'b1, 4'd0, E_F});
    v.push_back('{LW, 1'b1, 4'd1, E_D});
    v.push_back('{LW, 1'b0, 4'd2, E_MA});
    v.push_back('{BAD, 1'b0, 4'd3, E_MR});
    v.push_back('{SW, 1'b0, 4'd4, E_MWB | 16'd1});
    v.push_back('{SW, 1'b0, 4'd0, E_F | 16'd1});
    v.push_back('{SW, 1'b0, 4'd1, E_D | 16'd1});
    v.push_back('{SW, 1'b0, 4'd2, E_MA | 16'd1});
    v.push_back('{SW, 1'b1, 4'd5, E_MW | 16'd1});
    v.push_back('{RT, 1'b0, 4'd0, E_F});
    v.push_back('{RT, 1'b0, 4'd1, E_D});
    v.push_back('{LW, 1'b0, 4'd6, E_ER});
    v.push_back('{RT, 1'b0, 4'd8, E_AW});
    v.push_back('{IT, 1'b0, 4'd0, E_F});
    v.push_back('{IT, 1'b0, 4'd1, E_D});
    v.push_back('{IT, 1'b0, 4'd7, E_EI});
    v.push_back('{IT, 1'b0, 4'd8, E_AW});
    v.push_back('{BQ, 1'b1, 4'd0, E_F | 16'd2});
    v.push_back('{BQ, 1'b1, 4'd1, E_D | 16'd2});
    v.push_back('{BQ, 1'b1, 4'd9, E_B | PCW | 16'd2});
    v.push_back('{BQ, 1'b0, 4'd0, E_F | 16'd2});
    v.push_back('{BQ, 1'b0, 4'd1, E_D | 16'd2});
    v.push_back('{BQ, 1'b0, 4'd9, E_B | 16'd2});
    v.push_back('{JL, 1'b0, 4'd0, E_F | 16'd3});
    v.push_back('{JL, 1'b0, 4'd1, E_D | 16'd3});
    v.push_back('{JL, 1'b0, 4'd10, E_J | 16'd3});
    v.push_back('{JL, 1'b0, 4'd8, E_AW | 16'd3});
    v.push_back('{BAD, 1'b0, 4'd0, E_F});
    v.push_back('{BAD, 1'b0, 4'd1, E_D | ILL});
    v.push_back('{BAD, 1'b0, 4'd0, E_F});
    v.push_back('{SW, 1'b0, 4'd1, E_D | 16'd1});
    @(negedge clk);
    #1;
    check("reset_state", {12'd0, state}, 16'd0);
    check("reset_outs", outs, E_RST);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < v.size(); i++) begin
      op = v[i].op;
      zero = v[i].zero;
      #1;
      check($sformatf("vec%0d_state", i), {12'd0, state}, {12'd0, v[i].st});
      check($sformatf("vec%0d_outs", i), outs, v[i].o);
      @(negedge clk);
    end
    // the last vector leaves the FSM heading into a store; stop it inside MEMWRITE
    begin
      int n = 0;
      while (state !== 4'd5 && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("reach_memwrite", {12'd0, state}, 16'd5);
    end
    #2;
    check("memwrite_before_rst", {15'd0, mem_write}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_state", {12'd0, state}, 16'd0);
    check("async_rst_outs", outs, E_RST | 16'd1);
    @(negedge clk);
    check("held_rst_state", {12'd0, state}, 16'd0);
    check("held_rst_outs", outs, E_RST | 16'd1);
    rst_n = 1'b1;
    op = LW;
    #1;
    check("release_fetch_outs", outs, E_F);
    @(negedge clk);
    check("release_decode_state", {12'd0, state}, 16'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
- Multicycle RISC-V main controller. It is the initiating end of the alu_op interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath select and write enable, plus the 2-bit alu_op consumed by the ALU decoder.
- Sits in the controller next to the ALU decoder. Its inputs are the IR opcode and the ALU zero flag.

Parameters:
- STATE_W, 4, width of the state register and of the debug state port.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode field of the instruction register, instr[6:0].
- zero  in  1  ALU zero flag, valid in the BEQ state.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register and OldPC enable.
- result_src  out  2  result mux select: 00 ALUOut, 01 mem data, 10 ALU result.
- alu_src_a  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1.
- alu_src_b  out  2  ALU B select: 00 rs2, 01 immediate, 10 constant 4.
- alu_op  out  2  00 add, 01 subtract, 10 decode funct fields.
- reg_write  out  1  register file write enable.
- imm_src  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state  out  STATE_W  current state, for debug and verification.

Behaviour:
- Moore FSM. All outputs except pc_write, imm_src and illegal_op are pure functions of state.
- Any output not listed for a state is 0.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10
  - Codes 11-15 are unused and return to FETCH on the next edge.
- Reset:
  - rst_n low sets state to FETCH immediately, with no clock needed.
  - While rst_n is low, pc_write, ir_write, mem_write, reg_write and illegal_op are forced to 0. Selects show their FETCH values.
  - Reset mid-instruction abandons that instruction. No further writes occur until a FETCH cycle with rst_n high.
- Outputs per state:
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update=1.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (computes branch/jump target).
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
  - MEMREAD: result_src=00, adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1.
- pc_write = pc_update | (branch & zero), combinational.
- Transitions:
  - FETCH -> DECODE.
  - DECODE branches on op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other op -> FETCH, with illegal_op=1 during that DECODE cycle.
  - MEMADR -> MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECUTER, EXECUTEI, JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
- Instruction latency in cycles, counted from entering FETCH to re-entering FETCH:
  - lw 5
  - sw, R-type, I-type ALU, jal 4
  - beq 3
  - illegal opcode 2
- imm_src is combinational from op, independent of state:
  - lw, I-type ALU: 00
  - sw: 01
  - beq: 10
  - jal: 11
  - any other op: 00
- op is sampled only in DECODE and MEMADR. Changes to op in other states must not affect the state sequence.
- zero is used only in BEQ.

Test Plan:
- Reset and first fetch:
  - Assert rst_n=0 mid-MEMWRITE -> state=0 and mem_write=0 immediately, with no clock edge.
  - Release rst_n -> first edge moves to DECODE; ir_write=1 and pc_write=1 during the FETCH cycle.
- lw, op=0000011:
  - State sequence 0,1,2,3,4,0.
  - reg_write=1 only in state 4, with result_src=01.
  - imm_src=00.
- sw, op=0100011:
  - State sequence 0,1,2,5,0.
  - mem_write=1 only in state 5, with adr_src=1.
  - reg_write never 1.
- R-type then I-type (op=0110011, then 0010011):
  - State sequences 6,8 and 7,8 after DECODE.
  - alu_op=10 in states 6 and 7.
  - alu_src_b=00 in state 6, 01 in state 7.
- beq, op=1100011, run twice:
  - With zero=1: pc_write=1 in BEQ.
  - With zero=0: pc_write=0 in BEQ.
  - Both runs return to FETCH after 3 cycles; alu_op=01 in BEQ.
- jal, and illegal op=0000000:
  - jal follows 0,1,10,8,0 with pc_write=1 in state 10.
  - Illegal op gives illegal_op=1 for exactly one cycle in DECODE, then FETCH, with no reg_write or mem_write at any point.
